// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the decode-stage hazard controller: flush FSM
// state encoding and a helper that sizes the flush countdown register.
package hazard_ctrl_pkg;

    localparam int HZ_STATE_W = 1;

    typedef enum logic [HZ_STATE_W-1:0] {
        HZ_RUN   = 1'b0,
        HZ_FLUSH = 1'b1
    } hz_state_e;

    // The countdown holds at most FLUSH_CYCLES-1; keep at least one bit.
    function automatic int flush_cnt_w(input int cycles);
        return (cycles < 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Pending-write scoreboard: one saturating-by-hazard counter per
// architectural register (x0 has none), two busy lookups for the ID source
// operands, a saturation check on the ID destination and an idle flag.
module hazard_scoreboard
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_IDX_W = 5,
    parameter int CNT_W     = 2
) (
    input  logic                 clk,
    input  logic                 aresetn,
    input  logic [REG_IDX_W-1:0] rd_a,
    input  logic [REG_IDX_W-1:0] rd_b,
    input  logic [REG_IDX_W-1:0] dest,
    input  logic                 inc_en,
    input  logic                 dec_en,
    input  logic [REG_IDX_W-1:0] dec_reg,
    output logic                 busy_a,
    output logic                 busy_b,
    output logic                 dest_full,
    output logic                 idle
);
    localparam int NREG = 2 ** REG_IDX_W;

    logic [CNT_W-1:0] cnt_reg  [1:NREG-1];
    logic [CNT_W-1:0] cnt_next [1:NREG-1];
    logic [NREG-1:0]  nonzero;
    logic [NREG-1:0]  saturated;

    // x0 is hard-wired: never busy, never full.
    assign nonzero[0]   = 1'b0;
    assign saturated[0] = 1'b0;

    generate
        for (genvar gi = 1; gi < NREG; gi++) begin : g_reg
            logic inc_hit;
            logic dec_hit;
            assign inc_hit = inc_en && (dest == REG_IDX_W'(gi));
            assign dec_hit = dec_en && (dec_reg == REG_IDX_W'(gi));
            // Simultaneous issue and retirement on one register cancel out;
            // a retirement against an empty counter is dropped.
            assign cnt_next[gi] = (inc_hit && !dec_hit) ? cnt_reg[gi] + CNT_W'(1) :
                                  (dec_hit && !inc_hit && nonzero[gi]) ? cnt_reg[gi] - CNT_W'(1) :
                                  cnt_reg[gi];
            assign nonzero[gi]   = |cnt_reg[gi];
            assign saturated[gi] = &cnt_reg[gi];
        end
    endgenerate

    // Counter array update; reset empties every pending write.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            cnt_reg <= '{default: '0};
        end else begin
            for (int r = 1; r < NREG; r++) begin
                cnt_reg[r] <= cnt_next[r];
            end
        end
    end

    assign busy_a    = nonzero[rd_a];
    assign busy_b    = nonzero[rd_b];
    assign dest_full = saturated[dest];
    assign idle      = ~|nonzero;

    // A write-back retiring a register with nothing pending is a protocol error.
    a_no_underflow: assert property (@(posedge clk) disable iff (!aresetn)
        (dec_en && (dec_reg != '0)) |-> nonzero[dec_reg]);

endmodule

// File: rtl/hazard_ctrl.sv
// Decode-stage sequencing controller: combines scoreboard RAW/saturation
// hazards, branch flush and memory back-pressure into the stall/clear
// controls of the IF/ID and ID/EX pipeline registers.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_IDX_W    = 5,
    parameter int CNT_W        = 2,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 aresetn,
    input  logic                 i_id_valid,
    input  logic [REG_IDX_W-1:0] i_id_reg_a,
    input  logic [REG_IDX_W-1:0] i_id_reg_b,
    input  logic                 i_id_reg_a_used,
    input  logic                 i_id_reg_b_used,
    input  logic                 i_id_dest_en,
    input  logic [REG_IDX_W-1:0] i_id_dest_reg,
    input  logic                 i_wb_dest_en,
    input  logic [REG_IDX_W-1:0] i_wb_dest_reg,
    input  logic                 i_branch_taken,
    input  logic                 i_ext_stall,
    output logic                 o_if_stall,
    output logic                 o_id_stall,
    output logic                 o_if_clr,
    output logic                 o_id_clr,
    output logic                 o_idle
);
    localparam int FLUSH_W = flush_cnt_w(FLUSH_CYCLES);

    hz_state_e          state_reg, state_next;
    logic [FLUSH_W-1:0] flush_cnt_reg, flush_cnt_next;

    logic busy_a, busy_b, dest_full;
    logic hazard, issue, flushing;

    hazard_scoreboard #(
        .REG_IDX_W (REG_IDX_W),
        .CNT_W     (CNT_W)
    ) u_scoreboard (
        .clk       (clk),
        .aresetn   (aresetn),
        .rd_a      (i_id_reg_a),
        .rd_b      (i_id_reg_b),
        .dest      (i_id_dest_reg),
        .inc_en    (issue && i_id_dest_en),
        .dec_en    (i_wb_dest_en),
        .dec_reg   (i_wb_dest_reg),
        .busy_a    (busy_a),
        .busy_b    (busy_b),
        .dest_full (dest_full),
        .idle      (o_idle)
    );

    // Registered counter values only: a same-cycle write-back does not
    // release a waiting reader because the register file has no bypass.
    assign hazard = i_id_valid & ((i_id_reg_a_used & busy_a) |
                                  (i_id_reg_b_used & busy_b) |
                                  (i_id_dest_en & dest_full));
    assign issue    = i_id_valid & ~hazard & ~i_ext_stall & (state_reg == HZ_RUN) & ~i_branch_taken;
    assign flushing = i_branch_taken | (state_reg == HZ_FLUSH);

    // Flush FSM state register.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_reg     <= HZ_RUN;
            flush_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            flush_cnt_reg <= flush_cnt_next;
        end
    end

    // Flush FSM next state: a taken branch (re)loads the countdown.
    always_comb begin
        state_next     = state_reg;
        flush_cnt_next = flush_cnt_reg;
        if (i_branch_taken) begin
            if (FLUSH_CYCLES > 1) begin
                state_next     = HZ_FLUSH;
                flush_cnt_next = FLUSH_W'(FLUSH_CYCLES - 1);
            end
        end else if (state_reg == HZ_FLUSH) begin
            flush_cnt_next = flush_cnt_reg - FLUSH_W'(1);
            if (flush_cnt_reg == FLUSH_W'(1)) begin
                state_next = HZ_RUN;
            end
        end
    end

    // Pipeline controls: flush beats back-pressure beats hazard; clear beats stall.
    always_comb begin
        o_if_clr   = flushing;
        o_id_clr   = flushing | (hazard & ~i_ext_stall);
        o_if_stall = ~flushing & (hazard | i_ext_stall);
        o_id_stall = i_ext_stall & ~(flushing | (hazard & ~i_ext_stall));
        if (!aresetn) begin
            o_if_clr   = 1'b1;
            o_id_clr   = 1'b1;
            o_if_stall = 1'b0;
            o_id_stall = 1'b0;
        end
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the decode stage: it owns the `stall` and `clr` controls of the IF/ID and ID/EX pipeline registers. A per-register pending-write scoreboard detects read-after-write hazards on instructions sitting in ID. Branch redirects from EX produce a fixed-length flush. External back-pressure from the memory stage is merged in. It sits between the fetch/decode stages and the write-back stage, next to the register file it protects.

## Interface
- `REG_IDX_W`, 5: register index width; register count is 2**REG_IDX_W.
- `CNT_W`, 2: width of each per-register pending-write counter.
- `FLUSH_CYCLES`, 1: cycles of flush after a taken branch, ≥1.

- `clk`  in  1  clock; all state changes on rising edge.
- `aresetn`  in  1  asynchronous, active-low reset.
- `i_id_valid`  in  1  ID holds a real instruction.
- `i_id_reg_a` / `i_id_reg_b`  in  REG_IDX_W  source register indices of the ID instruction.
- `i_id_reg_a_used` / `i_id_reg_b_used`  in  1  the corresponding source is actually read.
- `i_id_dest_en`  in  1  the ID instruction writes a register.
- `i_id_dest_reg`  in  REG_IDX_W  destination index.
- `i_wb_dest_en`, `i_wb_dest_reg`  in  1 / REG_IDX_W  write-back retirement, same signals as the register-file write port.
- `i_branch_taken`  in  1  EX resolved a taken branch/jump this cycle.
- `i_ext_stall`  in  1  downstream (memory) stall request.
- `o_if_stall`  out  1  hold PC and IF/ID register.
- `o_id_stall`  out  1  hold the ID/EX register.
- `o_if_clr`  out  1  clear the IF/ID register.
- `o_id_clr`  out  1  clear the ID/EX register (bubble).
- `o_idle`  out  1  no writes pending in the scoreboard.

## Operation
- **Scoreboard:** one CNT_W-bit counter per register, `cnt[r]`. Register 0 has no counter and is never busy.
- **Hazard:** `hazard = i_id_valid & ((a_used & reg_a!=0 & cnt[reg_a]!=0) | (b_used & reg_b!=0 & cnt[reg_b]!=0) | (dest_en & dest!=0 & cnt[dest]==max))`. The last term covers counter saturation.
- A same-cycle WB retirement does NOT clear a hazard. The hazard uses the registered counter value, because the register file has no write-through.
- **Issue:** `issue = i_id_valid & ~hazard & ~i_ext_stall & state==RUN & ~i_branch_taken`.
- **Counter updates:**
  - `inc = issue & dest_en & dest!=0`.
  - `dec = i_wb_dest_en & wb_reg!=0`.
  - Per register: `inc` only gives +1; `dec` only gives −1; both on the same register leaves it unchanged.
  - A decrement of a zero counter is ignored; it is a protocol error, flagged by a simulation-only assertion.
- **FSM states: RUN, FLUSH.**
  - RUN: `i_branch_taken` moves to FLUSH with `flush_cnt = FLUSH_CYCLES-1`. If FLUSH_CYCLES==1, stay in RUN.
  - FLUSH: decrement `flush_cnt`; return to RUN when it reaches 0. Another `i_branch_taken` while in FLUSH reloads `flush_cnt`.
- **Output equations:**
  - `o_if_clr = i_branch_taken | state==FLUSH`.
  - `o_id_clr = i_branch_taken | state==FLUSH | (hazard & ~i_ext_stall)`.
  - `o_if_stall = ~o_if_clr & (hazard | i_ext_stall)`.
  - `o_id_stall = i_ext_stall & ~o_id_clr`.
- **Priority:** flush > ext_stall > hazard. Clear wins over stall on the same register.
- `o_idle = all cnt==0`.

## Timing
- All outputs are combinational from inputs and registered state, with zero-cycle latency.
- The scoreboard updates at the rising edge after `issue`/`dec`.
- Earliest dependent issue: the cycle after the WB retirement of the last pending write.
- Reset (`aresetn` low, any time):
  - All counters go to 0, state goes to RUN, `flush_cnt` goes to 0.
  - While reset is held: `o_if_clr = o_id_clr = 1`, `o_if_stall = o_id_stall = 0`, `o_idle = 1`.
  - Reset in the middle of a flush or stall discards all pending state.
- Release is synchronised by the reset tree; the first cycle after release behaves as RUN with an empty scoreboard.

## Structure
- Add to `config.vh`: `HZ_STATE_W` and the `HZ_RUN` / `HZ_FLUSH` encodings. `REG_IDX_W` reuses the existing register-index define.
- Sub-module `hazard_scoreboard`:
  - Contains the counter array, inc/dec, busy lookup for two read ports plus the dest saturation check, and `o_idle`.
  - The FSM and output logic stay in `hazard_ctrl`.

## Test plan
- **RAW stall:** issue `x5` writer, next instr reads `x5` → `o_if_stall=1`, `o_id_clr=1` each cycle until WB writes `x5`; the reader issues the cycle after.
- **x0 and unused sources:** writer to `x0`, then reader of `x0`, and a reader of `x7` with `reg_b_used=0` while `x7` is pending → no stall, `cnt` unchanged.
- **Saturation:** three back-to-back writers to `x3` with CNT_W=2, fourth writer → stall until one WB.
- **Simultaneous inc/dec:** issue and retire on `x9` in the same cycle → `cnt[9]` unchanged.
- **Branch:** FLUSH_CYCLES=2, branch during `i_ext_stall=1` and a pending hazard → `o_if_clr = o_id_clr = 1` for 2 cycles, stalls 0, no issue.
- **Reset mid-flight:** pending writes plus FLUSH state, pulse `aresetn` → `o_idle=1`, state RUN, a dependent reader issues immediately.
